// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with its own HI/LO pair, retiring StepBits result bits per CALC cycle.
// Optional macro MULDIV_EARLY_TERM_EN: a multiply leaves CALC once its remaining multiplier bits are zero.
module mul_div_unit #(
  parameter int DataWidth = 32,
  parameter int StepBits  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic                 divByZero,
  output logic [DataWidth-1:0] high,
  output logic [DataWidth-1:0] low
);
  localparam int W     = DataWidth;
  localparam int Steps = DataWidth / StepBits;
  localparam int CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd0, OP_MULTU = 4'd1, OP_DIV   = 4'd2, OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4, OP_MTLO  = 4'd5, OP_MADD  = 4'd6, OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8, OP_MSUBU = 4'd9;

  logic [1:0]      state;
  logic [2*W-1:0]  acc;     // multiply: running product; divide: {remainder, dividend/quotient}
  logic [2*W-1:0]  mcand;   // multiply: shifted multiplicand; divide: divisor in low half
  logic [W-1:0]    mplier;
  logic [CntW-1:0] cnt;
  logic            is_div, neg_q, neg_r, acc_add, acc_sub;

  logic            is_arith, op_signed, op_div, a_neg, b_neg, b_zero;
  logic [W-1:0]    a_mag, b_mag;

  always_comb begin
    is_arith  = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    op_signed = op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    op_div    = op inside {OP_DIV, OP_DIVU};
    a_neg     = op_signed & a[W-1];
    b_neg     = op_signed & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    b_zero    = (b == '0);
  end

  // One CALC cycle: StepBits chained shift-add or restoring-subtract stages.
  logic [2*W-1:0] acc_step, mc_step;
  logic [W-1:0]   mp_step;
  logic [W:0]     r_sh;

  always_comb begin
    acc_step = acc;
    mc_step  = mcand;
    mp_step  = mplier;
    r_sh     = '0;
    for (int i = 0; i < StepBits; i++) begin
      if (is_div) begin
        r_sh = {acc_step[2*W-1:W], acc_step[W-1]};
        if (r_sh >= {1'b0, mcand[W-1:0]})
          acc_step = {r_sh[W-1:0] - mcand[W-1:0], acc_step[W-2:0], 1'b1};
        else
          acc_step = {r_sh[W-1:0], acc_step[W-2:0], 1'b0};
      end else begin
        if (mp_step[0]) acc_step = acc_step + mc_step;
        mc_step = mc_step << 1;
        mp_step = mp_step >> 1;
      end
    end
  end

  logic early_exit;
`ifdef MULDIV_EARLY_TERM_EN
  assign early_exit = !is_div && (mp_step == '0);
`else
  assign early_exit = 1'b0;
`endif

  logic [2*W-1:0] prod, mul_res;
  logic [W-1:0]   quo, rem;

  always_comb begin
    prod = neg_q ? -acc : acc;
    if (acc_add)      mul_res = {high, low} + prod;
    else if (acc_sub) mul_res = {high, low} - prod;
    else              mul_res = prod;
    quo = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rem = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      high      <= '0;
      low       <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      acc_add   <= 1'b0;
      acc_sub   <= 1'b0;
    end else if (enable) begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (op == OP_MTHI) high <= a;
            else if (op == OP_MTLO) low <= a;
            else if (is_arith) begin
              state     <= CALC;
              cnt       <= CntW'(Steps - 1);
              is_div    <= op_div;
              acc_add   <= op inside {OP_MADD, OP_MADDU};
              acc_sub   <= op inside {OP_MSUB, OP_MSUBU};
              divByZero <= op_div & b_zero;
              mplier    <= b_mag;
              if (op_div) begin
                // b==0 runs unsigned on raw a: quotient all ones, remainder a
                acc   <= {{W{1'b0}}, b_zero ? a : a_mag};
                mcand <= {{W{1'b0}}, b_mag};
                neg_q <= ~b_zero & (a_neg ^ b_neg);
                neg_r <= ~b_zero & a_neg;
              end else begin
                acc   <= '0;
                mcand <= {{W{1'b0}}, a_mag};
                neg_q <= a_neg ^ b_neg;
                neg_r <= 1'b0;
              end
            end
          end
          CALC: begin
            acc    <= acc_step;
            mcand  <= mc_step;
            mplier <= mp_step;
            cnt    <= cnt - CntW'(1);
            if (cnt == '0 || early_exit) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            done  <= 1'b1;
            if (is_div) begin
              low  <= quo;
              high <= rem;
            end else begin
              {high, low} <= mul_res;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: two instances (StepBits 1 and 4) share stimulus; results and
// latencies are checked against a plain-arithmetic HI/LO model and a vector table.
module tb_mul_div_unit;
  logic        clock, reset, enable, start, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy1, done1, dbz1, busy4, done4, dbz4;
  logic [31:0] hi1, lo1, hi4, lo4;

  mul_div_unit #(.DataWidth(32), .StepBits(1)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy1), .done(done1), .divByZero(dbz1), .high(hi1), .low(lo1));

  mul_div_unit #(.DataWidth(32), .StepBits(4)) u4 (
    .clock(clock), .reset(reset), .enable(enable), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy4), .done(done4), .divByZero(dbz4), .high(hi4), .low(lo4));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int n_run = 0, n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;
  int lat1, lat4, dc1, dc4, bc1, bc4;
  logic [63:0] snap1, snap4;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;
  vec_t vec[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit arith(input logic [3:0] o);
    return o inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd9};
  endfunction

  // Edges from accept to HI/LO update; 0 for single-cycle/NOP ops.
  function automatic int exp_lat(input int k, input logic [3:0] o, input logic [31:0] bb);
    logic [31:0] mag;
    int nb, ch;
    if (!arith(o)) return 0;
    mag = 0; nb = 0; ch = 0;
`ifdef MULDIV_EARLY_TERM_EN
    if (!(o inside {4'd2, 4'd3})) begin
      mag = ((o inside {4'd0, 4'd6, 4'd8}) && bb[31]) ? -bb : bb;
      for (int i = 0; i < 32; i++) if (mag[i]) nb = i + 1;
      ch = (nb + k - 1) / k;
      if (ch < 1) ch = 1;
      return ch + 1;
    end
`endif
    return 32 / k + 1;
  endfunction

  task automatic model_apply(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb);
    logic [63:0] p, hl;
    int sa, sb;
    sa = aa; sb = bb; hl = {m_hi, m_lo};
    if (o inside {4'd0, 4'd6, 4'd8}) p = 64'(longint'(sa) * longint'(sb));
    else p = {32'd0, aa} * {32'd0, bb};
    case (o)
      4'd0, 4'd1: hl = p;
      4'd6, 4'd7: hl = hl + p;
      4'd8, 4'd9: hl = hl - p;
      4'd2, 4'd3: begin
        if (bb == 0) hl = {aa, 32'hFFFFFFFF};
        else if (o == 4'd2 && aa == 32'h80000000 && bb == 32'hFFFFFFFF) hl = {32'd0, 32'h80000000};
        else if (o == 4'd2) hl = {32'(sa % sb), 32'(sa / sb)};
        else hl = {aa % bb, aa / bb};
      end
      4'd4: hl[63:32] = aa;
      4'd5: hl[31:0] = aa;
      default: ;
    endcase
    if (arith(o)) m_dbz = (o inside {4'd2, 4'd3}) && (bb == 0);
    {m_hi, m_lo} = hl;
  endtask

  // Accept one op, then watch both instances until each has pulsed done (bounded).
  task automatic run_op(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb, input int intr);
    int n, lim;
    start = 1'b1; op = o; a = aa; b = bb;
    @(posedge clock); #1;
    start = 1'b0;
    lat1 = 0; lat4 = 0; dc1 = 0; dc4 = 0; bc1 = 0; bc4 = 0;
    snap1 = {hi1, lo1}; snap4 = {hi4, lo4};
    lim = arith(o) ? 100 : 2;
    n = 0;
    while (1) begin
      if (busy1) bc1++;
      if (busy4) bc4++;
      if (done1) begin dc1++; if (lat1 == 0) lat1 = n; end
      if (done4) begin dc4++; if (lat4 == 0) lat4 = n; end
      if (n == intr) begin start = 1'b1; op = 4'd3; a = 32'hFFFFFFFF; b = 32'd3; end
      else start = 1'b0;
      if (n >= lim || (arith(o) && lat1 != 0 && lat4 != 0)) break;
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string nm, input logic [3:0] o, input logic [31:0] bb,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed);
    chk({nm, " hilo1"}, {hi1, lo1}, {eh, el});
    chk({nm, " hilo4"}, {hi4, lo4}, {eh, el});
    chk({nm, " dbz1"}, 64'(dbz1), 64'(ed));
    chk({nm, " dbz4"}, 64'(dbz4), 64'(ed));
    chk({nm, " lat1"}, 64'(lat1), 64'(exp_lat(1, o, bb)));
    chk({nm, " lat4"}, 64'(lat4), 64'(exp_lat(4, o, bb)));
    chk({nm, " done1"}, 64'(dc1), arith(o) ? 64'd1 : 64'd0);
    chk({nm, " done4"}, 64'(dc4), arith(o) ? 64'd1 : 64'd0);
    chk({nm, " busy1"}, 64'(bc1), 64'(exp_lat(1, o, bb)));
    chk({nm, " busy4"}, 64'(bc4), 64'(exp_lat(4, o, bb)));
    if (!arith(o)) begin
      chk({nm, " early1"}, snap1, {eh, el});
      chk({nm, " early4"}, snap4, {eh, el});
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    vec[0]  = '{4'd4, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 1'b0};
    vec[1]  = '{4'd5, 32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 1'b0};
    vec[2]  = '{4'd0, 32'hFFFFFFFE, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};
    vec[3]  = '{4'd1, 32'hFFFFFFFE, 32'd7,        32'h00000006, 32'hFFFFFFF2, 1'b0};
    vec[4]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vec[5]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vec[6]  = '{4'd3, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vec[7]  = '{4'd4, 32'h0,        32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b1};
    vec[8]  = '{4'd5, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 1'b1};
    vec[9]  = '{4'd7, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 1'b0};
    vec[10] = '{4'd8, 32'd1,        32'd2,        32'h00000000, 32'hFFFFFFFE, 1'b0};
    vec[11] = '{4'd2, 32'h80000000, 32'd0,        32'h80000000, 32'hFFFFFFFF, 1'b1};
    vec[12] = '{4'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vec[13] = '{4'd12, 32'hDEADBEEF, 32'd1,       32'h00000002, 32'h0000000E, 1'b0};
    vec[14] = '{4'd1, 32'hFFFFFFFF, 32'd3,        32'h00000002, 32'hFFFFFFFD, 1'b0};
    vec[15] = '{4'd9, 32'd3,        32'd5,        32'h00000002, 32'hFFFFFFEE, 1'b0};
    vec[16] = '{4'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vec[17] = '{4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vec[18] = '{4'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};

    reset = 1'b1; enable = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset u1", {busy1, done1, dbz1, hi1, lo1}, '0);
    chk("reset u4", {busy4, done4, dbz4, hi4, lo4}, '0);
    reset = 1'b0;

    foreach (vec[i]) begin
      run_op(vec[i].op, vec[i].a, vec[i].b, -1);
      model_apply(vec[i].op, vec[i].a, vec[i].b);
      check_op($sformatf("vec%0d", i), vec[i].op, vec[i].b, vec[i].hi, vec[i].lo, vec[i].dbz);
    end

    // Flush in mid-CALC: no done, HI/LO untouched, divByZero cleared by the accept.
    start = 1'b1; op = 4'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    m_dbz = 1'b0;
    chk("flush busy1", 64'(busy1), 64'd0);
    chk("flush busy4", 64'(busy4), 64'd0);
    n = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done1 || done4) n++;
    end
    chk("flush done", 64'(n), 64'd0);
    chk("flush hilo1", {hi1, lo1}, {m_hi, m_lo});
    chk("flush hilo4", {hi4, lo4}, {m_hi, m_lo});

    // Flush in IDLE blocks a simultaneous start.
    start = 1'b1; flush = 1'b1; op = 4'd4; a = 32'hDEADBEEF;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    @(posedge clock); #1;
    chk("idle flush hi1", 64'(hi1), 64'(m_hi));
    chk("idle flush hi4", 64'(hi4), 64'(m_hi));
    chk("idle flush busy", 64'({busy1, busy4}), 64'd0);

    // A start while busy is ignored.
    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3);
    model_apply(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("busy start", 4'd1, 32'hFFFFFFFF, m_hi, m_lo, m_dbz);

    // enable low freezes a running op, and holds done without re-pulsing.
    start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("freeze busy", 64'(busy1), 64'd1);
    chk("freeze hilo", {hi1, lo1}, {m_hi, m_lo});
    enable = 1'b1;
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("freeze lat", 64'(n), 64'd33);
    model_apply(4'd3, 32'd100, 32'd7);
    enable = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("done hold", 64'(done1), 64'd1);
    chk("hold hilo1", {hi1, lo1}, {m_hi, m_lo});
    chk("hold hilo4", {hi4, lo4}, {m_hi, m_lo});
    enable = 1'b1;
    @(posedge clock); #1;
    chk("done clear", 64'(done1), 64'd0);

    // Reset mid-operation clears everything.
    run_op(4'd4, 32'hA5A5A5A5, 32'd0, -1);
    model_apply(4'd4, 32'hA5A5A5A5, 32'd0);
    start = 1'b1; op = 4'd0; a = 32'hFFFFFFFE; b = 32'h80000001;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midreset u1", {busy1, done1, dbz1, hi1, lo1}, '0);
    chk("midreset u4", {busy4, done4, dbz4, hi4, lo4}, '0);
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 11));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, -1);
      model_apply(ro, ra, rb);
      check_op($sformatf("rnd%0d op%0d a=%h b=%h", i, ro, ra, rb), ro, rb, m_hi, m_lo, m_dbz);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative, parametrised multiply/divide unit with its own HI/LO register pair. It is the multi-cycle successor to the CPU's combinational multiplier, divider and HI/LO registers. It retires StepBits result bits per clock, and it provides a start/busy/done handshake so the core can stall on dependent MFHI/MFLO. It also supports a pipeline flush and MTHI/MTLO writes.

Parameters:
DataWidth, 32, operand and HI/LO width; must be even and at least 8.
StepBits, 1, result bits retired per CALC cycle; must divide DataWidth; allowed values 1, 2, 4.
Steps, DataWidth/StepBits, derived localparam; number of CALC cycles.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high; clears all state.
enable  in  1  global enable; when low, all state holds (including mid-operation).
start  in  1  request; sampled with op, a and b.
op  in  4  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6=MADD, 7=MADDU, 8=MSUB, 9=MSUBU; others are NOP.
a  in  DataWidth  multiplicand / dividend / MTHI-MTLO data.
b  in  DataWidth  multiplier / divisor.
flush  in  1  cancel the in-flight operation.
busy  out  1  operation in progress; start is ignored while high.
done  out  1  one-cycle pulse in the first cycle HI/LO show a new arithmetic result.
divByZero  out  1  sticky flag: last DIV/DIVU had b==0; cleared by the next accepted arithmetic op.
high  out  DataWidth  committed HI.
low  out  DataWidth  committed LO.

Behaviour:
- The clock port is named clock and the reset port is named reset. Reset is synchronous, active-high, and is the only reset.
- On reset: state=IDLE; high=0, low=0; busy=0; done=0; divByZero=0. Reset wins over every other input, including mid-operation.
- enable=0 freezes every register. done is held, not re-pulsed.
- Acceptance: at a rising edge where enable & start & ~busy & ~flush.
- MTHI/MTLO are single-cycle:
  - MTHI writes high=a at the accept edge; MTLO writes low=a.
  - No busy, no done.
- NOP op: the request is accepted and discarded.
- FSM for arithmetic ops: IDLE -> CALC (Steps cycles) -> FIX (1 cycle) -> IDLE.
  - Accept edge: load operand magnitudes. For signed ops take |a| and |b| and record the result sign(s). Clear divByZero, or set it if DIV/DIVU with b==0.
  - CALC: per edge retire StepBits bits.
    - Multiply: shift-add over a 2*DataWidth accumulator.
    - Divide: restoring division, StepBits chained subtract stages.
    - An iteration counter counts Steps-1 down to 0.
  - FIX edge:
    - Apply sign correction.
    - Multiply: {high,low} = product. For MADD*/MSUB*, {high,low} = {high,low} +/- product (2*DataWidth arithmetic, wraps modulo 2^(2*DataWidth)). The HI/LO operand is the value committed at the FIX edge.
    - Divide: low = quotient (truncated toward zero); high = remainder (sign of dividend).
  - busy=1 in CALC and FIX. done=1 in the cycle after the FIX edge, together with the new high/low; busy=0 in that same cycle.
  - Latency: accept edge to HI/LO update = Steps+1 edges. A new start can be accepted in the same cycle done=1.
- Divide boundaries:
  - b==0: low = all ones; high = a; divByZero=1.
  - Signed MIN / -1: low = MIN; high = 0.
- Flush: at an edge with flush=1, the FSM returns to IDLE and busy=0 next cycle.
  - HI/LO are unchanged; no done pulse.
  - flush in IDLE has no effect, and start in that cycle is not accepted.
- high and low are registered outputs and always reflect committed state, never partial results.

Optional Feature:
Macro MULDIV_EARLY_TERM_EN.
- Defined: for multiply ops, if the remaining unprocessed multiplier bits are all zero at a CALC edge, CALC exits to FIX on the next edge. Minimum latency is 2 edges, e.g. b==0 or b < 2^StepBits. Results are bit-identical to the non-terminating path. Divide latency is unchanged.
- Not defined: all multiply ops take exactly Steps+1 edges.

Test Plan:
- Reset and single-cycle writes: apply reset, then MTHI a=0x12345678, then MTLO a=0xCAFEBABE -> high=0x12345678 and low=0xCAFEBABE one edge after each; busy and done stay 0.
- Signed multiply (DataWidth=32, StepBits=1): MULT a=0xFFFFFFFE, b=7 -> busy for 33 cycles; then {high,low}=0xFFFFFFFF_FFFFFFF2 and done pulses once. With MULTU on the same operands -> high=0x00000006, low=0xFFFFFFF2.
- Signed divide: DIV a=-7, b=2 -> low=0xFFFFFFFD, high=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> low=0x80000000, high=0.
  - DIVU a=5, b=0 -> low=0xFFFFFFFF, high=5, divByZero=1.
- Accumulate: preset HI=0, LO=0xFFFFFFFF, then MADDU a=1, b=1 -> high=1, low=0. Then MSUB a=1, b=2 -> {high,low}=0x00000000_FFFFFFFE.
- Flush and reset mid-operation:
  - MULT started, flush at CALC cycle 10 -> busy=0 next cycle, HI/LO unchanged, no done.
  - Repeat with reset at cycle 10 -> all outputs 0.
  - start asserted while busy -> ignored; result equals the first op's result.
- StepBits=4 and MULDIV_EARLY_TERM_EN: MULTU a=0xFFFFFFFF, b=3 -> result after 2 edges, low=0xFFFFFFFD, high=2. DIVU 100/7 still takes 9 edges -> low=14, high=2.
